// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver: 16x-oversampled UART receive controller delivering one byte per frame with error flags.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority vote per bit, decision on the cnt==8 tick).
module uart_receiver (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       sample_i,
    input  logic       rx_i,
    input  logic [1:0] data_bits_i,
    input  logic [1:0] parity_mode_i,
    input  logic       stop_bits_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       parity_error_o,
    output logic       frame_error_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        parity_of = (^d) ^ odd;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic       w_complete;
    logic       r_rx_meta;
    logic       r_rx_sync;
    logic       w_rx_s;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [2:0] r_last_idx;
    logic       r_stop_idx;
    logic [7:0] r_shift;
    logic       r_armed;
    logic [1:0] r_parity_mode;
    logic       r_stop_bits;
    logic       r_perr_pend;
    logic       r_ferr_pend;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_perr;
    logic       r_ferr;
    logic       r_busy;
    logic       w_decide;
    logic       w_wrap;
    logic       w_bit;
    logic       w_parity_en;

    assign w_rx_s      = r_rx_sync;
    assign w_wrap      = sample_i && (r_cnt == 4'd15);
    assign w_parity_en = (r_parity_mode == 2'd1) || (r_parity_mode == 2'd2);

`ifdef UART_RX_MAJORITY_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] r_early;

    // Early votes taken on the cnt==6 and cnt==7 ticks.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_early <= 2'b11;
        end else if (sample_i && (r_cnt == 4'd6)) begin
            r_early[0] <= w_rx_s;
        end else if (sample_i && (r_cnt == 4'd7)) begin
            r_early[1] <= w_rx_s;
        end else begin
            r_early <= r_early;
        end
    end

    assign w_decide = sample_i && (r_cnt == 4'd8);
    assign w_bit    = majority3(r_early[0], r_early[1], w_rx_s);
`else
    assign w_decide = sample_i && (r_cnt == 4'd7);
    assign w_bit    = w_rx_s;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Frame sequencing: next state and completion strobe.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        if (!enable_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s && r_armed) begin
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_START: begin
                    if (w_decide && w_bit) begin
                        w_state_next = S_IDLE;
                    end else if (w_wrap) begin
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_START;
                    end
                end
                S_DATA: begin
                    if (w_wrap && (r_idx == r_last_idx)) begin
                        w_state_next = w_parity_en ? S_PARITY : S_STOP;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
                S_PARITY: begin
                    if (w_wrap) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_state_next = S_PARITY;
                    end
                end
                S_STOP: begin
                    // The frame ends at the final stop bit's decision point, not at its end.
                    if (w_decide && (r_stop_idx == r_stop_bits)) begin
                        w_state_next = S_IDLE;
                        w_complete   = 1'b1;
                    end else begin
                        w_state_next = S_STOP;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Tick counter, frame datapath, pending errors and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt         <= 4'd0;
            r_idx         <= 3'd0;
            r_last_idx    <= 3'd7;
            r_stop_idx    <= 1'b0;
            r_shift       <= 8'd0;
            r_armed       <= 1'b0;
            r_parity_mode <= 2'd0;
            r_stop_bits   <= 1'b0;
            r_perr_pend   <= 1'b0;
            r_ferr_pend   <= 1'b0;
            r_data        <= 8'd0;
            r_valid       <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_busy  <= (w_state_next != S_IDLE);
            r_valid <= w_complete;

            if (w_state_next != r_state) begin
                r_cnt <= 4'd0;
            end else if (sample_i) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            // Completion disarms so a held-low line yields only one break frame.
            if (w_complete) begin
                r_armed <= 1'b0;
            end else if (w_rx_s) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end

            if ((r_state == S_IDLE) && (w_state_next == S_START)) begin
                r_last_idx    <= {1'b0, data_bits_i} + 3'd4;
                r_parity_mode <= parity_mode_i;
                r_stop_bits   <= stop_bits_i;
                r_shift       <= 8'd0;
                r_idx         <= 3'd0;
                r_stop_idx    <= 1'b0;
                r_perr_pend   <= 1'b0;
                r_ferr_pend   <= 1'b0;
            end else begin
                if ((r_state == S_DATA) && w_decide) begin
                    r_shift[r_idx] <= w_bit;
                end
                if ((r_state == S_DATA) && w_wrap) begin
                    r_idx <= r_idx + 3'd1;
                end
                if ((r_state == S_PARITY) && w_decide) begin
                    r_perr_pend <= (w_bit != parity_of(r_shift, (r_parity_mode == 2'd2)));
                end
                if ((r_state == S_STOP) && w_decide && !w_bit) begin
                    r_ferr_pend <= 1'b1;
                end
                if ((r_state == S_STOP) && w_wrap) begin
                    r_stop_idx <= 1'b1;
                end
            end

            if (w_complete) begin
                r_data <= r_shift;
                r_perr <= r_perr_pend;
                r_ferr <= r_ferr_pend | ~w_bit;
            end else begin
                r_data <= r_data;
                r_perr <= r_perr;
                r_ferr <= r_ferr;
            end
        end
    end

    assign data_o         = r_data;
    assign valid_o        = r_valid;
    assign parity_error_o = r_perr;
    assign frame_error_o  = r_ferr;
    assign busy_o         = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sample = 1'b0;
    logic       rx;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_error_o;
    logic       frame_error_o;
    logic       busy_o;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_wide = 0;
    int         n_busy_valid = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         valid_cyc = 0;
    logic [7:0] cap_data = 8'd0;
    logic       cap_pe = 1'b0;
    logic       cap_fe = 1'b0;
    logic       prev_valid = 1'b0;
    logic [1:0] div_cnt = 2'd0;

    uart_receiver dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .sample_i       (sample),
        .rx_i           (rx),
        .data_bits_i    (data_bits),
        .parity_mode_i  (parity_mode),
        .stop_bits_i    (stop_bits),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .parity_error_o (parity_error_o),
        .frame_error_o  (frame_error_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in with divider 3: one tick every 4 clocks.
    always @(posedge clk) begin
        cyc++;
        div_cnt <= div_cnt + 2'd1;
        sample  <= (div_cnt == 2'd3);
    end

    always @(negedge clk) begin
        if (valid_o) begin
            n_valid++;
            valid_cyc = cyc;
            cap_data  = data_o;
            cap_pe    = parity_error_o;
            cap_fe    = frame_error_o;
            if (prev_valid) n_wide++;
            if (busy_o) n_busy_valid++;
        end
        prev_valid = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (sample !== 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        rx = v;
        for (int j = 1; j <= 16; j++) begin
            wait_tick();
            if (glitch && j == 7) rx = ~v;
            else if (glitch && j == 8) rx = v;
        end
    endtask

    // Expected parity bit from the count of ones in the data word.
    function automatic logic ref_parity(input int nbits, input logic [7:0] d, input int pmode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return (pmode == 2) ? logic'((ones + 1) % 2) : logic'(ones % 2);
    endfunction

    task automatic ref_result(input int nbits, input logic [7:0] d, input int pmode, input bit pflip,
                              input int nstop, input logic [1:0] stops,
                              output logic [7:0] ed, output logic ep, output logic ef);
        ed = d & 8'((1 << nbits) - 1);
        ep = (pmode == 1 || pmode == 2) ? pflip : 1'b0;
        ef = (nstop == 1) ? !stops[0] : !(stops[0] && stops[1]);
    endtask

    task automatic send_frame(input int nbits, input logic [7:0] d, input int pmode, input bit pflip,
                              input int nstop, input logic [1:0] stops, input bit glitch, input bit scramble);
        data_bits   = 2'(nbits - 5);
        parity_mode = 2'(pmode);
        stop_bits   = (nstop == 2);
        wait_tick();
        start_cyc = cyc;
        send_bit(1'b0, 1'b0);
        if (scramble) begin
            data_bits   = 2'($urandom_range(0, 3));
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nbits; i++) send_bit(d[i], glitch);
        if (pmode == 1 || pmode == 2) send_bit(ref_parity(nbits, d, pmode) ^ pflip, 1'b0);
        for (int s = 0; s < nstop; s++) send_bit(stops[s], 1'b0);
        rx = 1'b1;
    endtask

    task automatic frame_test(input string tag, input int nbits, input logic [7:0] d, input int pmode,
                              input bit pflip, input int nstop, input logic [1:0] stops, input bit scramble);
        int         v0;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        ref_result(nbits, d, pmode, pflip, nstop, stops, ed, ep, ef);
        v0 = n_valid;
        send_frame(nbits, d, pmode, pflip, nstop, stops, 1'b0, scramble);
        check({tag, " valid"}, n_valid - v0, 1);
        check({tag, " data"}, cap_data, ed);
        check({tag, " perr"}, cap_pe, ep);
        check({tag, " ferr"}, cap_fe, ef);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0;
        int         busy_cnt;
        int         lat;
        int         nb;
        int         pm;
        int         ns;
        logic [7:0] d;
        logic [1:0] st;

        rst_n = 1'b0; enable = 1'b1; rx = 1'b1;
        data_bits = 2'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst data", data_o, 8'h00);
        check("rst valid", valid_o, 1'b0);
        check("rst perr", parity_error_o, 1'b0);
        check("rst ferr", frame_error_o, 1'b0);
        check("rst busy", busy_o, 1'b0);
        rst_n = 1'b1;

        busy_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
        end
        check("idle valid", n_valid, 0);
        check("idle busy", busy_cnt, 0);
        check("idle data", data_o, 8'h00);
        check("idle flags", {parity_error_o, frame_error_o}, 2'b00);

        frame_test("8N1 A5", 8, 8'hA5, 0, 1'b0, 1, 2'b11, 1'b0);
`ifdef UART_RX_MAJORITY_EN
        lat = 4 * (16 * 9 + 9);
`else
        lat = 4 * (16 * 9 + 8);
`endif
        check("8N1 latency", valid_cyc - start_cyc, lat);
        frame_test("8N1 3C", 8, 8'h3C, 0, 1'b0, 1, 2'b11, 1'b0);
        idle(8);

        frame_test("7E2 55", 7, 8'h55, 1, 1'b0, 2, 2'b11, 1'b0);
        idle(8);
        frame_test("7E2 55 flip", 7, 8'h55, 1, 1'b1, 2, 2'b11, 1'b0);
        idle(8);

        v0 = n_valid;
        wait_tick();
        rx = 1'b0;
        repeat (4) wait_tick();
        rx = 1'b1;
        check("glitch busy", busy_o, 1'b1);
        repeat (20) wait_tick();
        check("glitch valid", n_valid - v0, 0);
        check("glitch idle", busy_o, 1'b0);

        v0 = n_valid;
        data_bits = 2'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        wait_tick();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        check("abort busy before", busy_o, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort busy next", busy_o, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        enable = 1'b1;
        idle(16);
        check("abort valid", n_valid - v0, 0);

        v0 = n_valid;
        data_bits = 2'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        wait_tick();
        rx = 1'b0;
        repeat (3 * 160) wait_tick();
        check("break valid", n_valid - v0, 1);
        check("break data", cap_data, 8'h00);
        check("break ferr", cap_fe, 1'b1);
        check("break perr", cap_pe, 1'b0);
        idle(32);
        frame_test("after break 81", 8, 8'h81, 0, 1'b0, 1, 2'b11, 1'b0);
        idle(8);

        v0 = n_valid;
        send_frame(8, 8'h5A, 0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
        check("glitch5A valid", n_valid - v0, 1);
`ifdef UART_RX_MAJORITY_EN
        check("glitch5A data", cap_data, 8'h5A);
`else
        check("glitch5A data", cap_data, 8'hA5);
`endif
        idle(8);

        v0 = n_valid;
        data_bits = 2'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        wait_tick();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst data", data_o, 8'h00);
        check("midrst busy", busy_o, 1'b0);
        idle(64);
        check("midrst valid", n_valid - v0, 0);
        frame_test("after rst C3", 8, 8'hC3, 2, 1'b0, 1, 2'b11, 1'b0);
        idle(8);

        for (int k = 0; k < 25; k++) begin
            nb = 5 + $urandom_range(0, 3);
            pm = $urandom_range(0, 3);
            ns = 1 + $urandom_range(0, 1);
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            frame_test($sformatf("rnd%0d", k), nb, d, pm, ($urandom_range(0, 3) == 0), ns, st, 1'b1);
            idle(1 + $urandom_range(0, 20));
        end

        check("valid width", n_wide, 0);
        check("busy with valid", n_busy_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive controller sequencing a 16x-oversampling baud tick from the UART baud generator. It detects start bits, samples data, parity and stop bits at mid-bit, and delivers one parallel byte per frame with error flags to the UART register/FIFO layer. The divider programmed into the baud generator must be `clk_freq / (16 * baud) - 1`.

## Interface
- No parameters.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `enable_i`  in  1  receiver enable; low forces IDLE.
- `sample_i`  in  1  one-cycle tick at 16x baud, from the baud generator.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_bits_i`  in  2  frame width: 0=5, 1=6, 2=7, 3=8 bits.
- `parity_mode_i`  in  2  0/3=none, 1=even, 2=odd.
- `stop_bits_i`  in  1  0=one stop bit, 1=two stop bits.
- `data_o`  out  8  received word, right-aligned, unused upper bits 0.
- `valid_o`  out  1  one-cycle pulse: new word on `data_o`.
- `parity_error_o`  out  1  parity mismatch for the word on `data_o`.
- `frame_error_o`  out  1  a stop bit sampled low for the word on `data_o`.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- `rx_i` passes through a 2-FF synchronizer (reset value 1). All sampling uses the synchronized value `rx_s`.
- 4-bit tick counter `cnt` advances only on `sample_i`. It is cleared on every state entry and wraps 15->0 at each bit boundary.
- Decision point: the bit value is fixed on the tick where `cnt==7`. With the majority feature enabled, see Configuration.
- States:
  - IDLE: requires `armed` (`rx_s` seen high since the last frame or reset). A low `rx_s` with `enable_i=1` and `armed` moves to START. `data_bits_i`, `parity_mode_i` and `stop_bits_i` are latched on this transition, so changes mid-frame have no effect.
  - START: at the decision point, value 1 means a glitch: return to IDLE with no flags and no valid. Otherwise continue to DATA at `cnt` wrap.
  - DATA: samples LSB first into `shift[idx]`. `idx` runs from 0 to N-1. After bit N-1 wraps, go to PARITY if parity is enabled, else STOP.
  - PARITY: the sampled bit is compared with XOR(data) for even, ~XOR(data) for odd. A mismatch sets the pending parity error.
  - STOP: sample each stop bit. Any low sample sets the pending frame error. The frame completes at the decision point of the final stop bit, without waiting for the bit to end, then returns to IDLE.
- On completion: `data_o`, `parity_error_o` and `frame_error_o` are loaded, and `valid_o` pulses. These outputs hold until the next completion.
- Completion clears `armed`. A break (line held low) yields one frame with `data_o=0` and `frame_error_o=1`, and no further frames until `rx_s` returns high.
- `enable_i` low in any state: next cycle goes to IDLE, pending frame discarded, no `valid_o`.
- There is no receive buffer. Overrun handling belongs to the consumer, which must accept `valid_o` every cycle.

## Timing
- Reset values: `data_o=0`, `valid_o=0`, `parity_error_o=0`, `frame_error_o=0`, `busy_o=0`, state IDLE, `armed=0`, `cnt=0`.
- Reset asserted mid-frame aborts the frame with no `valid_o`.
- Start detect: 2 clocks of synchronizer latency, plus 1 clock to register the START state.
- `valid_o` is asserted in the clock cycle after the `sample_i` tick that decides the final stop bit. It lasts exactly one cycle.
- `busy_o` falls in the same cycle `valid_o` rises.
- A new start edge can be accepted from the cycle after `valid_o`, as soon as `armed` is set again.
- Bit period is 16 ticks. Frame latency from the falling start edge to `valid_o` is about (1 + N + P + S - 0.5) bit times, plus up to 1 tick of edge-detection jitter.

## Configuration
- Macro `UART_RX_MAJORITY_EN`.
- Defined: each bit value is the 2-of-3 majority of `rx_s` sampled on ticks `cnt==6,7,8`. The decision point moves to the `cnt==8` tick, and all decision-point timing above shifts by one tick.
- Undefined: a single sample at `cnt==7`, with no sample storage logic.

## Test plan
- Reset and idle: `rx_i` held at 1 for 1000 cycles with divider 3 → no `valid_o`, `busy_o=0`, all outputs 0.
- 8N1 byte: frame 0xA5 → `data_o=0xA5`, one `valid_o` pulse, both error flags 0; then back-to-back frame 0x3C → second pulse with 0x3C.
- 7E2 parity: 7-bit 0x55 with correct even parity → `data_o=0x55`, `parity_error_o=0`. Same frame with the parity bit flipped → `parity_error_o=1`.
- Glitch and abort: a 4-tick low pulse on `rx_i` → return to IDLE, no `valid_o`. Separately, `enable_i` dropped during DATA → no `valid_o`, `busy_o=0` next cycle.
- Break: `rx_i` held low for 3 frame times in 8N1 → exactly one `valid_o` with `data_o=0x00`, `frame_error_o=1`. Next frame 0x81 after the line returns high → 0x81 received cleanly.
- Majority (macro defined): a 1-tick inverted glitch at `cnt==7` on each data bit of 0x5A → `data_o=0x5A`. Macro undefined → corrupted data expected.
